// File: rtl/psum_accum_drain_pkg.sv
// Shared constants, FSM encoding and output saturation for the partial-sum accumulator.
package psum_accum_drain_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StRel,
        StSat,
        StOut
    } state_e;

    // Clamp a signed value into the int16 range.
    function automatic logic [LANE_W-1:0] saturate_int16(input longint x);
        if (x > longint'(32767)) begin
            return 16'h7fff;
        end else if (x < longint'(-32768)) begin
            return 16'h8000;
        end else begin
            return x[LANE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/psum_lane_acc.sv
// One accumulator lane: wrap-around signed accumulate, then registered shift-and-saturate.
module psum_lane_acc
    import psum_accum_drain_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic                     add_i,
    input  logic                     load_i,
    input  logic signed [LANE_W-1:0] psum_i,
    output logic        [LANE_W-1:0] data_o
);

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  shifted;
    logic        [LANE_W-1:0] data_q, data_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + {{(ACC_W-LANE_W){psum_i[LANE_W-1]}}, psum_i};
        end
    end

    always_comb begin
        shifted = acc_q >>> SHIFT;
        data_d  = data_q;
        if (load_i) begin
            data_d = saturate_int16(longint'(shifted));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            data_q <= '0;
        end else begin
            acc_q  <= acc_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/psum_accum_drain.sv
// Job sequencer: counts tiles from a 16x16 dot-product array, accumulates 16 lanes,
// then saturates and holds the result until the downstream accepts it.
module psum_accum_drain
    import psum_accum_drain_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                num_tiles,
    output logic                      tile_en,
    output logic [7:0]                tile_idx,
    input  logic [LANES*LANE_W-1:0]   psum_in,
    input  logic                      psum_fin,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    state_e     state_q, state_d;
    logic [7:0] tiles_q, tiles_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] idx_inc;
    logic       fin_q;
    logic       capture;
    logic       acc_clr, acc_add, out_load;

    // fin_q follows psum_fin in every state, so a level already high on entry is no edge.
    assign capture = psum_fin & ~fin_q;
    assign idx_inc = idx_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        tiles_d  = tiles_q;
        idx_d    = idx_q;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        out_load = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    tiles_d = (num_tiles == 8'd0) ? 8'd1 : num_tiles;
                    idx_d   = 8'd0;
                    acc_clr = 1'b1;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (capture) begin
                    acc_add = 1'b1;
                    idx_d   = idx_inc;
                    state_d = (idx_inc < tiles_q) ? StRel : StSat;
                end
            end
            StRel: state_d = StAccum;
            StSat: begin
                out_load = 1'b1;
                state_d  = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tiles_q <= 8'd0;
            idx_q   <= 8'd0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tiles_q <= tiles_d;
            idx_q   <= idx_d;
            fin_q   <= psum_fin;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        psum_lane_acc #(
            .ACC_W (ACC_W),
            .SHIFT (SHIFT)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (acc_clr),
            .add_i  (acc_add),
            .load_i (out_load),
            .psum_i (psum_in[LANE_W*(LANES-i)-1 -: LANE_W]),
            .data_o (out_data[LANE_W*(LANES-i)-1 -: LANE_W])
        );
    end

    assign tile_en   = (state_q == StAccum);
    assign tile_idx  = idx_q;
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_psum_accum_drain.sv
// Directed + randomized bench for psum_accum_drain; two instances (SHIFT=0 and SHIFT=2) share stimulus.
module tb_psum_accum_drain;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   num_tiles = 8'd0;
    logic [255:0] psum_in = '0;
    logic         psum_fin = 1'b0;
    logic         out_ready = 1'b0;

    logic         tile_en, out_valid, busy;
    logic [7:0]   tile_idx;
    logic [255:0] out_data;
    logic         tile_en2, out_valid2, busy2;
    logic [7:0]   tile_idx2;
    logic [255:0] out_data2;

    int checks = 0;
    int failures = 0;
    longint sums [16];

    psum_accum_drain #(.ACC_W(32), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .tile_en(tile_en),
        .tile_idx(tile_idx), .psum_in(psum_in), .psum_fin(psum_fin), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    psum_accum_drain #(.ACC_W(32), .SHIFT(2)) dut_s2 (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .tile_en(tile_en2),
        .tile_idx(tile_idx2), .psum_in(psum_in), .psum_fin(psum_fin), .out_data(out_data2),
        .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected output vector: sum of every captured tile, shifted and clamped to int16.
    function automatic logic [255:0] exp_vec(input int sh);
        logic [255:0] v;
        longint s;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            s = sums[i] >>> sh;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            v[255-16*i -: 16] = s[15:0];
        end
        return v;
    endfunction

    function automatic logic [255:0] rand_tile();
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[255-16*i -: 16] = 16'($urandom);
        return v;
    endfunction

    function automatic logic [255:0] fill_tile(input logic [15:0] val);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[255-16*i -: 16] = val;
        return v;
    endfunction

    task automatic start_job(input logic [7:0] n);
        num_tiles = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_tiles = 8'($urandom);
        for (int i = 0; i < 16; i++) sums[i] = 0;
        chk("start_ctl", 256'({busy, busy2, tile_en, tile_en2, out_valid, out_valid2}),
            256'(6'b111100));
        chk("start_idx", 256'({tile_idx, tile_idx2}), 256'(16'h0000));
    endtask

    task automatic do_tile(input logic [255:0] data, input logic [7:0] idx, input bit last,
                           input int lat);
        logic signed [15:0] l;
        logic [7:0] nidx;
        nidx = idx + 8'd1;
        repeat (lat) tick();
        chk("accum_wait", 256'({tile_en, tile_en2, tile_idx}), 256'({2'b11, idx}));
        psum_in = data;
        psum_fin = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            l = data[255-16*i -: 16];
            sums[i] += longint'(l);
        end
        psum_in = rand_tile();
        psum_fin = 1'b0;
        chk("after_capture", 256'({tile_en, tile_en2, tile_idx, tile_idx2}),
            256'({2'b00, nidx, nidx}));
        if (!last) begin
            tick();
            chk("rel_one_cycle", 256'({tile_en, tile_en2, busy}), 256'(3'b111));
        end else begin
            chk("sat_no_valid", 256'({out_valid, out_valid2, busy}), 256'(3'b001));
            tick();
            chk("out_valid", 256'({out_valid, out_valid2, tile_en}), 256'(3'b110));
            chk("out_data_s0", out_data, exp_vec(0));
            chk("out_data_s2", out_data2, exp_vec(2));
        end
    endtask

    task automatic drain(input int hold, input bit poke_start);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (poke_start && k == 1) begin
                start = 1'b1;
                num_tiles = 8'd3;
            end
            tick();
            start = 1'b0;
            chk("hold_valid", 256'({out_valid, out_valid2, tile_en}), 256'(3'b110));
            chk("hold_data", out_data, exp_vec(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("to_idle", 256'({out_valid, out_valid2, busy, busy2, tile_en}), 256'(5'b0));
    endtask

    initial begin
        logic [255:0] t;
        int n;

        for (int i = 0; i < 16; i++) sums[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_ctl", 256'({tile_en, out_valid, busy, tile_idx}), 256'd0);
        chk("reset_data", out_data | out_data2, 256'd0);

        // Single tile, all lanes 100.
        start_job(8'd1);
        do_tile(fill_tile(16'sd100), 8'd0, 1'b1, 2);
        chk("single_100", out_data, fill_tile(16'sd100));
        drain(0, 1'b0);

        // Three tiles, lane 0 sums to 2500.
        start_job(8'd3);
        t = rand_tile(); t[255:240] = 16'sd1000;
        do_tile(t, 8'd0, 1'b0, 1);
        t = rand_tile(); t[255:240] = 16'sd2000;
        do_tile(t, 8'd1, 1'b0, 0);
        t = rand_tile(); t[255:240] = -16'sd500;
        do_tile(t, 8'd2, 1'b1, 3);
        chk("three_lane0", 256'(out_data[255:240]), 256'(16'sd2500));
        drain(0, 1'b0);

        // Saturation on lanes 5/6, then backpressure with an ignored start.
        start_job(8'd4);
        for (int k = 0; k < 4; k++) begin
            t = rand_tile();
            t[255-16*5 -: 16] = 16'sd32767;
            t[255-16*6 -: 16] = 16'h8000;
            do_tile(t, 8'(k), k == 3, 1);
        end
        chk("sat_s0", 256'({out_data[175:160], out_data[159:144]}), 256'(32'h7fff_8000));
        chk("sat_s2", 256'({out_data2[175:160], out_data2[159:144]}), 256'(32'h7fff_8000));
        drain(10, 1'b1);

        // Reset in the middle of a 4-tile job.
        start_job(8'd4);
        do_tile(rand_tile(), 8'd0, 1'b0, 0);
        do_tile(rand_tile(), 8'd1, 1'b0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ctl", 256'({tile_en, out_valid, busy, tile_idx}), 256'd0);
        chk("midrst_data", out_data | out_data2, 256'd0);
        start_job(8'd1);
        do_tile(rand_tile(), 8'd0, 1'b1, 1);
        drain(1, 1'b0);

        // num_tiles=0 with finish already high at start.
        psum_fin = 1'b1;
        tick();
        start_job(8'd0);
        psum_fin = 1'b1;
        repeat (3) tick();
        chk("stale_fin", 256'({tile_en, tile_idx}), 256'({1'b1, 8'd0}));
        psum_fin = 1'b0;
        tick();
        do_tile(rand_tile(), 8'd0, 1'b1, 0);
        drain(0, 1'b0);

        // Randomized jobs; out_ready may be high while nothing is valid.
        for (int j = 0; j < 6; j++) begin
            n = $urandom_range(1, 5);
            out_ready = 1'($urandom);
            start_job(8'(n));
            for (int k = 0; k < n; k++) begin
                do_tile(rand_tile(), 8'(k), k == n - 1, $urandom_range(0, 3));
            end
            drain($urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
